lcd_frame_writer: RTL
=====================

Name: lcd_frame_writer

Overview:
Downstream consumer of the PPU pixel stream. Captures each pushed 2-bit shade into a double-buffered (ping-pong) frame store of WIDTH x HEIGHT pixels. The frame store lives in external BRAM; only the write port is driven here. The block swaps front/back buffers at VBlank so the video scan-out side always reads a complete frame. When the LCD is disabled, it clears the back buffer to shade 0 and presents it as a blank frame.

Parameters:
WIDTH, 160, visible pixels per line
HEIGHT, 144, visible lines per frame
ADDR_W, 16, frame-store address width; must hold 2*WIDTH*HEIGHT (46080)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
pixel_in  in  2  shade index from PPU (post-palette)
pixel_valid_in  in  1  one-cycle strobe: pixel_in valid, consume now
vblank_in  in  1  PPU VBlank level
lcd_enable_in  in  1  LCDC bit 7
wr_addr_out  out  ADDR_W  frame-store write address
wr_data_out  out  2  frame-store write data
wr_en_out  out  1  frame-store write enable
front_buf_out  out  1  buffer index scan-out must read (0/1)
frame_done_out  out  1  one-cycle pulse on each buffer swap
overflow_out  out  1  sticky: pixel received after WIDTH*HEIGHT in one frame
short_frame_out  out  1  one-cycle pulse: VBlank entered before frame complete

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous, active-high.
- Reset values: all outputs 0. Internal pixel count = 0. back buffer = 1. State = WAIT_FRAME.
- Shared constant FRAME_PIX = WIDTH*HEIGHT. pix_cnt counts 0..FRAME_PIX, width $clog2(FRAME_PIX+1).
- Address = (back_buf ? FRAME_PIX : 0) + pix_cnt. Computed with an add or a mux-offset, no multiplier. Linear pixel order is row-major: x + y*WIDTH.
- States:
  - WAIT_FRAME: ignore pixel_valid_in. Go to DRAW on the falling edge of vblank_in while lcd_enable_in=1, or immediately when lcd_enable_in=1 and vblank_in=0 on the first cycle after reset. Go to CLEAR if lcd_enable_in=0.
  - DRAW: each pixel_valid_in writes one pixel. Registered write, latency 1: wr_en_out=1 in the cycle after the strobe, with the matching addr/data. pix_cnt then increments.
    - pix_cnt reaches FRAME_PIX → WAIT_VBLANK.
    - Strobe while pix_cnt==FRAME_PIX → no write; overflow_out←1. Only reset clears it.
    - vblank_in rises while pix_cnt<FRAME_PIX → short_frame_out pulse; no swap; pix_cnt←0; → WAIT_FRAME.
  - WAIT_VBLANK: vblank_in rising edge → swap. front_buf_out←back_buf, back_buf←~back_buf, frame_done_out pulse, pix_cnt←0, → WAIT_FRAME. Any strobe here sets overflow_out and is dropped.
  - CLEAR: one write of shade 0 per cycle over the whole back buffer. wr_en_out is continuous, pix_cnt increments each cycle. At FRAME_PIX → swap exactly as in WAIT_VBLANK, then → BLANK_HOLD.
  - BLANK_HOLD: no writes. lcd_enable_in rising → WAIT_FRAME.
- lcd_enable_in falling in any state except CLEAR/BLANK_HOLD → abandon the current frame (no swap), pix_cnt←0, → CLEAR on the next cycle. A pending registered write from the previous cycle still completes.
- Simultaneous pixel_valid_in and vblank_in rising in DRAW: the pixel is written and counted first, then the VBlank rule is evaluated on the updated pix_cnt. Completing the frame in that cycle counts as a full frame and goes straight to the swap.
- vblank_in edges come from a 1-cycle registered copy of vblank_in.
- Reset mid-clear or mid-draw: immediate return to reset values. The buffer contents are undefined.

Decomposition:
- Package lcd_pkg: WIDTH/HEIGHT defaults, FRAME_PIX, and the typedef enum logic[2:0] {WAIT_FRAME, DRAW, WAIT_VBLANK, CLEAR, BLANK_HOLD} lcd_wr_state_t.
- Optional sub-module edge_detect (registered rise/fall pulses), reused for vblank_in and lcd_enable_in.
- The address/counter logic stays inline.

Test Plan:
- Reset, then vblank 1→0, then 23040 strobes of shade 2 → wr_addr 23040..46079 (back_buf=1). Then vblank rises → frame_done pulse, front_buf_out=1, next frame writes 0..23039.
- 100 strobes, then vblank rises → short_frame pulse, front_buf_out unchanged, next frame restarts at offset 0 of the same back buffer.
- Full frame plus 1 extra strobe before vblank → extra pixel not written, overflow_out=1 and stays high through subsequent frames until rst_in.
- lcd_enable_in drops mid-DRAW at pix_cnt=5000 → 23040 consecutive writes of data 0 over the back buffer, then swap + frame_done, wr_en_out then 0 until enable returns.
- Final (23040th) strobe in the same cycle vblank rises → pixel written at last address, frame_done pulse the following cycle, no short_frame.
- rst_in asserted mid-CLEAR → next cycle all outputs 0, state WAIT_FRAME, back_buf=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and state type for the LCD frame-store writer.
package lcd_pkg;

    localparam int LCD_WIDTH  = 160;
    localparam int LCD_HEIGHT = 144;
    localparam int FRAME_PIX  = LCD_WIDTH * LCD_HEIGHT;
    localparam int LCD_ADDR_W = 16;

    typedef enum logic [2:0] {
        WAIT_FRAME  = 3'd0,
        DRAW        = 3'd1,
        WAIT_VBLANK = 3'd2,
        CLEAR       = 3'd3,
        BLANK_HOLD  = 3'd4
    } lcd_wr_state_t;

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Pixel stream in, frame-store write port and status out.
interface lcd_frame_writer_if #(
    parameter int ADDR_W = 16
);
    logic [1:0]        pixel_in;
    logic              pixel_valid_in;
    logic              vblank_in;
    logic              lcd_enable_in;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [1:0]        wr_data_out;
    logic              wr_en_out;
    logic              front_buf_out;
    logic              frame_done_out;
    logic              overflow_out;
    logic              short_frame_out;

    // PPU / environment side
    modport master (
        output pixel_in, pixel_valid_in, vblank_in, lcd_enable_in,
        input  wr_addr_out, wr_data_out, wr_en_out, front_buf_out,
        input  frame_done_out, overflow_out, short_frame_out
    );

    // Frame writer side
    modport slave (
        input  pixel_in, pixel_valid_in, vblank_in, lcd_enable_in,
        output wr_addr_out, wr_data_out, wr_en_out, front_buf_out,
        output frame_done_out, overflow_out, short_frame_out
    );
endinterface

// File: rtl/lcd_frame_writer_edge_detect.sv
// Rise/fall detection against a one-cycle registered copy of the input.
module edge_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_in,
    output logic rise_out,
    output logic fall_out
);

    logic prev_r;

    // Previous-cycle copy of the monitored level
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= sig_in;
        end
    end

    assign rise_out = sig_in & ~prev_r;
    assign fall_out = ~sig_in & prev_r;

endmodule

// File: rtl/lcd_frame_writer.sv
// Captures the PPU pixel stream into a ping-pong frame store and swaps
// buffers at VBlank; blanks the back buffer while the LCD is disabled.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int WIDTH  = LCD_WIDTH,
    parameter int HEIGHT = LCD_HEIGHT,
    parameter int ADDR_W = LCD_ADDR_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    lcd_frame_writer_if.slave bus
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam logic [CNT_W-1:0]  NPIX_CNT  = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] NPIX_ADDR = ADDR_W'(NPIX);

    lcd_wr_state_t     state_r;
    logic [CNT_W-1:0]  pix_cnt_r;
    logic              back_buf_r;
    logic              first_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [1:0]        wr_data_r;
    logic              wr_en_r;
    logic              front_buf_r;
    logic              frame_done_r;
    logic              overflow_r;
    logic              short_frame_r;

    logic              vb_rise_s;
    logic              vb_fall_s;
    logic              en_rise_s;
    logic              en_fall_s;
    logic              cnt_full_s;
    logic [ADDR_W-1:0] pix_addr_s;
    logic [CNT_W-1:0]  draw_cnt_s;

    edge_detect u_vblank_edge (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sig_in   (bus.vblank_in),
        .rise_out (vb_rise_s),
        .fall_out (vb_fall_s)
    );

    edge_detect u_enable_edge (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sig_in   (bus.lcd_enable_in),
        .rise_out (en_rise_s),
        .fall_out (en_fall_s)
    );

    assign cnt_full_s = (pix_cnt_r == NPIX_CNT);
    assign pix_addr_s = (back_buf_r ? NPIX_ADDR : {ADDR_W{1'b0}}) + ADDR_W'(pix_cnt_r);

    // Pixel count after this cycle's strobe, so VBlank sees the updated value
    always_comb begin
        draw_cnt_s = pix_cnt_r;
        if (bus.pixel_valid_in && !cnt_full_s) begin
            draw_cnt_s = pix_cnt_r + CNT_ONE;
        end else begin
            draw_cnt_s = pix_cnt_r;
        end
    end

    // Writer FSM with registered write port and status outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r       <= WAIT_FRAME;
            pix_cnt_r     <= {CNT_W{1'b0}};
            back_buf_r    <= 1'b1;
            first_r       <= 1'b1;
            wr_addr_r     <= {ADDR_W{1'b0}};
            wr_data_r     <= 2'b00;
            wr_en_r       <= 1'b0;
            front_buf_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            overflow_r    <= 1'b0;
            short_frame_r <= 1'b0;
        end else begin
            first_r       <= 1'b0;
            wr_en_r       <= 1'b0;
            frame_done_r  <= 1'b0;
            short_frame_r <= 1'b0;
            case (state_r)
                WAIT_FRAME: begin
                    if (!bus.lcd_enable_in) begin
                        pix_cnt_r <= {CNT_W{1'b0}};
                        state_r   <= CLEAR;
                    end else if (vb_fall_s || (first_r && !bus.vblank_in)) begin
                        state_r <= DRAW;
                    end
                end
                DRAW: begin
                    if (en_fall_s) begin
                        pix_cnt_r <= {CNT_W{1'b0}};
                        state_r   <= CLEAR;
                    end else begin
                        if (bus.pixel_valid_in && !cnt_full_s) begin
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= pix_addr_s;
                            wr_data_r <= bus.pixel_in;
                        end else if (bus.pixel_valid_in) begin
                            overflow_r <= 1'b1;
                        end
                        if (vb_rise_s) begin
                            // A frame completed in this very cycle still swaps
                            if (draw_cnt_s == NPIX_CNT) begin
                                front_buf_r  <= back_buf_r;
                                back_buf_r   <= ~back_buf_r;
                                frame_done_r <= 1'b1;
                            end else begin
                                short_frame_r <= 1'b1;
                            end
                            pix_cnt_r <= {CNT_W{1'b0}};
                            state_r   <= WAIT_FRAME;
                        end else if (draw_cnt_s == NPIX_CNT) begin
                            pix_cnt_r <= draw_cnt_s;
                            state_r   <= WAIT_VBLANK;
                        end else begin
                            pix_cnt_r <= draw_cnt_s;
                        end
                    end
                end
                WAIT_VBLANK: begin
                    if (en_fall_s) begin
                        pix_cnt_r <= {CNT_W{1'b0}};
                        state_r   <= CLEAR;
                    end else begin
                        if (bus.pixel_valid_in) begin
                            overflow_r <= 1'b1;
                        end
                        if (vb_rise_s) begin
                            front_buf_r  <= back_buf_r;
                            back_buf_r   <= ~back_buf_r;
                            frame_done_r <= 1'b1;
                            pix_cnt_r    <= {CNT_W{1'b0}};
                            state_r      <= WAIT_FRAME;
                        end
                    end
                end
                CLEAR: begin
                    // Swap only after the last zero write has been issued
                    if (cnt_full_s) begin
                        front_buf_r  <= back_buf_r;
                        back_buf_r   <= ~back_buf_r;
                        frame_done_r <= 1'b1;
                        pix_cnt_r    <= {CNT_W{1'b0}};
                        state_r      <= BLANK_HOLD;
                    end else begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= pix_addr_s;
                        wr_data_r <= 2'b00;
                        pix_cnt_r <= pix_cnt_r + CNT_ONE;
                    end
                end
                BLANK_HOLD: begin
                    if (en_rise_s) begin
                        state_r <= WAIT_FRAME;
                    end
                end
                default: begin
                    pix_cnt_r <= {CNT_W{1'b0}};
                    state_r   <= WAIT_FRAME;
                end
            endcase
        end
    end

    assign bus.wr_addr_out     = wr_addr_r;
    assign bus.wr_data_out     = wr_data_r;
    assign bus.wr_en_out       = wr_en_r;
    assign bus.front_buf_out   = front_buf_r;
    assign bus.frame_done_out  = frame_done_r;
    assign bus.overflow_out    = overflow_r;
    assign bus.short_frame_out = short_frame_r;

endmodule
